spi_tx: RTL and testbench
=========================

// Module: spi_tx
// PURPOSE
//  SPI-style serial transmitter: the outbound counterpart of spi_rx.
//  Shifts a parallel word out on serial_out and generates serial_clock, paced by a shared clk_en strobe.
//  A one-deep holding register lets the next word be queued while the current word shifts, so consecutive words go out back-to-back.
//  Sits between a byte producer (command/config logic) and an external IC's data-in pin.
// PARAMETERS
//  DATA_W     8  bits per word; legal range 2..32
//  MSB_FIRST  1  1: bit DATA_W-1 goes out first; 0: bit 0 goes out first
// PORTS
//  clk          in   1       system clock; all logic is on the rising edge
//  rst_n        in   1       asynchronous active-low reset
//  clk_en       in   1       serial-rate strobe; each high cycle permits one serial_clock rising edge
//  wr_en        in   1       write strobe; accepted only when ready=1
//  data_in      in   DATA_W  word to transmit; sampled on the accepted wr_en
//  ready        out  1       holding register empty; combinational = !hold_valid
//  busy         out  1       shifting or hold_valid; combinational
//  sent         out  1       one-cycle pulse when the last bit of a word completes
//  serial_out   out  1       data to the IC; stable while serial_clock is high
//  serial_clock out  1       to the IC; the IC samples serial_out on its rising edge
//  cs_n         out  1       present only with SPI_TX_CS_EN
// BEHAVIOUR
//  Reset (async): state=IDLE, hold_valid=0, bit_cnt=0, serial_clock=0, serial_out=0, sent=0 (cs_n=1).
//  FSM states:
//   IDLE:
//    - wr_en: load data_in directly into shift_reg (bypassing hold), bit_cnt<=0, state<=SHIFT.
//    - serial_out shows the first bit on the next cycle; latency wr_en -> first bit = 1 clk.
//   SHIFT:
//    - serial_clock=1 (high phase): serial_clock<=0 next cycle. High phase is exactly one clk.
//    - Falling edge with bit_cnt<DATA_W-1: shift, bit_cnt++, next bit onto serial_out in the same edge.
//    - Falling edge with bit_cnt==DATA_W-1: sent<=1, then
//      - hold_valid: load from hold, clear hold_valid, stay SHIFT;
//      - else wr_en: load data_in, stay SHIFT;
//      - else: state<=IDLE; serial_out keeps the last bit.
//    - serial_clock=0 and clk_en: serial_clock<=1.
//    - clk_en arriving while serial_clock=1 is ignored, not queued.
//   Queuing in SHIFT: wr_en&&ready stores data_in into hold, hold_valid<=1.
//   Dropped writes: wr_en&&!ready is dropped silently, with no state change.
//  Word time: DATA_W serial_clock pulses. Continuous clk_en gives 2*DATA_W clks per word.
//  Back-to-back: no idle serial period between consecutive words.
//  Simultaneous events:
//   - Completion with hold empty plus wr_en: the word is loaded straight to shift_reg; ready stays 1.
//   - Completion with hold_valid=1 plus wr_en: ready=0, so the write is dropped.
//  Reset mid-word: serial_clock low and outputs to reset values asynchronously; no sent pulse; queued data is discarded.
// CONFIGURATION
//  SPI_TX_CS_EN defined:
//   - cs_n goes low on the clk after the word is loaded into shift_reg (same edge as state->SHIFT).
//   - cs_n stays low across back-to-back words.
//   - cs_n returns high on the clk the FSM enters IDLE (same edge sent rises).
//   - Reset value 1.
//  SPI_TX_CS_EN undefined: the cs_n port and its logic are absent; the IC's chip select is managed externally.
// STRUCTURE
//  spi_pkg: state enum {IDLE, SHIFT} and the bit-counter width function clog2(DATA_W).
//   spi_rx takes the same enum when it is next revised.
//  Sub-module spi_tx_hold: one-deep holding register (wr, rd, data, valid). The FSM and shifter stay in spi_tx.
// TESTING
//  1. Single word:
//     - Stimulus: DATA_W=8, MSB_FIRST=1, clk_en every 4th clk, write 0xA5.
//     - Response: at the 8 serial_clock rising edges serial_out = 1,0,1,0,0,1,0,1; one sent pulse; busy clears; back in IDLE.
//  2. Back-to-back:
//     - Stimulus: clk_en tied high, write 0x3C, then 0xC3 while shifting.
//     - Response: 16 pulses in 32 clks; bits 00111100 11000011; two sent pulses 16 clks apart.
//  3. Overflow:
//     - Stimulus: during 0x11 write 0x22, then 0x33 while ready=0.
//     - Response: only 0x11 and 0x22 transmitted; 0x33 dropped.
//  4. Completion plus write:
//     - Stimulus: assert wr_en(0x5A) on the last-bit falling-edge clk with hold empty.
//     - Response: 0x5A starts with no gap; one sent pulse for the prior word.
//  5. Reset:
//     - Stimulus: rst_n low after 3 bits of 0xFF with 0x0F queued.
//     - Response: serial_clock=0, serial_out=0, ready=1, busy=0; no sent; 0x0F never sent.
//  6. Options:
//     - Stimulus: MSB_FIRST=0, 0x01 with SPI_TX_CS_EN.
//     - Response: serial_out 1,0,0,0,0,0,0,0; cs_n low from the load edge until the sent edge.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI FSM state type and counter-width helper
package spi_pkg;

    typedef enum logic {IDLE, SHIFT} spi_state_e;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/spi_tx_hold.sv
// spi_tx_hold: one-deep holding register queuing the next word while the current one shifts
module spi_tx_hold #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              valid
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = wr ? 1'b1 : (rd ? 1'b0 : valid_q);
        data_d  = wr ? wr_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid   = valid_q;
    assign rd_data = data_q;

endmodule

// File: rtl/spi_tx.sv
// spi_tx: SPI-style serial transmitter with one-deep queue; SPI_TX_CS_EN adds a cs_n output
module spi_tx
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              busy,
    output logic              sent,
    output logic              serial_out,
    output logic              serial_clock
`ifdef SPI_TX_CS_EN
    ,
    output logic              cs_n
`endif
);

    localparam int CNT_W = clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sclk_q, sclk_d, sout_q, sout_d, sent_q, sent_d;
    logic              hold_valid, hold_wr, hold_rd, last_fall, load;
    logic [DATA_W-1:0] hold_data, load_data;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    spi_tx_hold #(.DATA_W(DATA_W)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (hold_wr),
        .rd      (hold_rd),
        .wr_data (data_in),
        .rd_data (hold_data),
        .valid   (hold_valid)
    );

    // A write landing on the last falling edge with hold empty bypasses the hold
    always_comb begin
        last_fall = state_q == SHIFT && sclk_q && bit_cnt_q == LAST;
        load      = (state_q == IDLE && wr_en) || (last_fall && (hold_valid || wr_en));
        load_data = hold_valid ? hold_data : data_in;
        hold_rd   = last_fall && hold_valid;
        hold_wr   = state_q == SHIFT && wr_en && !hold_valid && !last_fall;
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sout_d    = sout_q;
        sent_d    = last_fall;
        sclk_d    = state_q == SHIFT && !sclk_q && clk_en;
        if (load) begin
            state_d   = SHIFT;
            shift_d   = load_data;
            bit_cnt_d = '0;
            sout_d    = first_bit(load_data);
        end else if (last_fall) begin
            state_d = IDLE;
        end else if (state_q == SHIFT && sclk_q) begin
            shift_d   = MSB_FIRST ? shift_q << 1 : shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            sout_d    = first_bit(shift_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sout_q    <= 1'b0;
            sent_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            sout_q    <= sout_d;
            sent_q    <= sent_d;
        end
    end

`ifdef SPI_TX_CS_EN
    logic cs_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cs_n_q <= 1'b1;
        else        cs_n_q <= state_d != SHIFT;
    end

    assign cs_n = cs_n_q;
`endif

    assign ready        = !hold_valid;
    assign busy         = state_q == SHIFT || hold_valid;
    assign sent         = sent_q;
    assign serial_out   = sout_q;
    assign serial_clock = sclk_q;

endmodule

// File: tb/tb_spi_tx.sv
// tb_spi_tx: directed self-checking bench for spi_tx (MSB-first and LSB-first instances)
module tb_spi_tx;

    logic       clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
    logic       wr_en = 1'b0, wr_en_l = 1'b0;
    logic [7:0] data_in = '0, data_in_l = '0;
    logic       ready, busy, sent, serial_out, serial_clock;
    logic       ready_l, busy_l, sent_l, serial_out_l, serial_clock_l;
`ifdef SPI_TX_CS_EN
    logic       cs_n, cs_n_l;
`endif
    int         n_chk = 0, n_fail = 0, cyc = 0, en_div = 1;
    logic       bits[$], bits_l[$];
    int         sent_t[$], sent_tl[$];
    logic       sp = 1'b0, spl = 1'b0;

    spi_tx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en), .data_in(data_in),
        .ready(ready), .busy(busy), .sent(sent), .serial_out(serial_out), .serial_clock(serial_clock)
`ifdef SPI_TX_CS_EN
        , .cs_n(cs_n)
`endif
    );

    spi_tx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_en(wr_en_l), .data_in(data_in_l),
        .ready(ready_l), .busy(busy_l), .sent(sent_l), .serial_out(serial_out_l), .serial_clock(serial_clock_l)
`ifdef SPI_TX_CS_EN
        , .cs_n(cs_n_l)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) clk_en = (cyc % en_div) == 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture serial_out at each serial_clock rise and the cycle of each sent pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            sp  = 1'b0;
            spl = 1'b0;
        end else begin
            if (serial_clock && !sp) bits.push_back(serial_out);
            if (serial_clock_l && !spl) bits_l.push_back(serial_out_l);
            if (sent) sent_t.push_back(cyc);
            if (sent_l) sent_tl.push_back(cyc);
`ifdef SPI_TX_CS_EN
            if (sent_l) chk("t6_cs_at_sent", {31'd0, cs_n_l}, 32'd1);
`endif
            sp  = serial_clock;
            spl = serial_clock_l;
        end
    end

    task automatic do_write(input bit lsb, input logic [7:0] d);
        @(negedge clk);
        if (lsb) begin wr_en_l = 1'b1; data_in_l = d; end
        else     begin wr_en = 1'b1;   data_in = d;   end
        @(negedge clk);
        wr_en   = 1'b0;
        wr_en_l = 1'b0;
    endtask

    task automatic wait_idle(input bit lsb, input string tag);
        for (int k = 0; k < 1000 && (lsb ? busy_l : busy); k++) @(negedge clk);
        chk(tag, {31'd0, lsb ? busy_l : busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] pack(input bit lsb);
        logic [31:0] v = '0;
        if (lsb) foreach (bits_l[i]) v = {v[30:0], bits_l[i]};
        else     foreach (bits[i])   v = {v[30:0], bits[i]};
        return v;
    endfunction

    function automatic int gap();
        return sent_t.size() > 1 ? sent_t[1] - sent_t[0] : -1;
    endfunction

    task automatic clear();
        bits.delete();
        bits_l.delete();
        sent_t.delete();
        sent_tl.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sclk", {31'd0, serial_clock}, 32'd0);
        chk("rst_sout", {31'd0, serial_out}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sent", {31'd0, sent}, 32'd0);
`ifdef SPI_TX_CS_EN
        chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // 1: single word, slow strobe
        en_div = 4;
        clear();
        do_write(0, 8'hA5);
        chk("t1_first_bit", {31'd0, serial_out}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_idle(0, "t1_idle");
        chk("t1_nbits", bits.size(), 32'd8);
        chk("t1_word", pack(0), 32'hA5);
        chk("t1_nsent", sent_t.size(), 32'd1);
        chk("t1_ready", {31'd0, ready}, 32'd1);
        // 2: back-to-back via hold
        en_div = 1;
        repeat (2) @(negedge clk);
        clear();
        do_write(0, 8'h3C);
        do_write(0, 8'hC3);
        wait_idle(0, "t2_idle");
        chk("t2_nbits", bits.size(), 32'd16);
        chk("t2_word", pack(0), 32'h3CC3);
        chk("t2_nsent", sent_t.size(), 32'd2);
        chk("t2_gap", gap(), 32'd16);
        // 3: overflow drop
        clear();
        do_write(0, 8'h11);
        do_write(0, 8'h22);
        chk("t3_ready_full", {31'd0, ready}, 32'd0);
        do_write(0, 8'h33);
        wait_idle(0, "t3_idle");
        chk("t3_nbits", bits.size(), 32'd16);
        chk("t3_word", pack(0), 32'h1122);
        chk("t3_nsent", sent_t.size(), 32'd2);
        // 4: write coincident with the last falling edge, hold empty
        clear();
        do_write(0, 8'hF0);
        repeat (14) @(negedge clk);
        do_write(0, 8'h5A);
        chk("t4_ready", {31'd0, ready}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        wait_idle(0, "t4_idle");
        chk("t4_word", pack(0), 32'hF05A);
        chk("t4_nsent", sent_t.size(), 32'd2);
        chk("t4_gap", gap(), 32'd16);
        // 5: async reset mid-word with a queued word
        clear();
        do_write(0, 8'hFF);
        do_write(0, 8'h0F);
        repeat (4) @(negedge clk);
        chk("t5_sout_pre", {31'd0, serial_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_sclk", {31'd0, serial_clock}, 32'd0);
        chk("t5_sout", {31'd0, serial_out}, 32'd0);
        chk("t5_ready", {31'd0, ready}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bits.delete();
        repeat (40) @(negedge clk);
        chk("t5_nbits_after", bits.size(), 32'd0);
        chk("t5_nsent", sent_t.size(), 32'd0);
        // 6: LSB-first instance
        clear();
        do_write(1, 8'h01);
        chk("t6_first_bit", {31'd0, serial_out_l}, 32'd1);
`ifdef SPI_TX_CS_EN
        chk("t6_cs_low", {31'd0, cs_n_l}, 32'd0);
        repeat (8) @(negedge clk);
        chk("t6_cs_mid", {31'd0, cs_n_l}, 32'd0);
`endif
        wait_idle(1, "t6_idle");
        chk("t6_nbits", bits_l.size(), 32'd8);
        chk("t6_seq", pack(1), 32'h80);
        chk("t6_nsent", sent_tl.size(), 32'd1);
`ifdef SPI_TX_CS_EN
        chk("t6_cs_end", {31'd0, cs_n_l}, 32'd1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
